// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display controller.
// Holds the conversion FSM state type, digit count, conversion widths and the
// active-low digit-to-segment table ({g,f,e,d,c,b,a}).
package seven_seg_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StConvert = 2'd1,
        StCommit  = 2'd2
    } state_e;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NUM_W      = 13;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

    // Counter value loaded on accept; CONVERT runs while it counts 12 down to 0.
    localparam logic [3:0] BIT_CNT_INIT = 4'd12;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Packed so that SEG_TABLE[d] is the code for decimal digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seven_seg_ctrl_seg7_decode.sv
// Combinational digit-to-segment decoder.
// Ports:
//   digit_i  - 4-bit digit value (10..15 decode to all segments off)
//   blank_i  - force all segments off (leading-zero blanking)
//   seg_o    - active-low segments {g,f,e,d,c,b,a}
module seg7_decode (
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    import seven_seg_pkg::*;

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (digit_i < 4'd10)) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

// File: rtl/seven_seg_ctrl.sv
// Binary-to-BCD converter driving a 4-digit multiplexed seven-segment display.
// A load in IDLE starts a 13-cycle double-dabble conversion followed by one
// COMMIT cycle that publishes the new digits; the display scan runs freely.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   num      - 13-bit binary value, captured on an accepted load
//   load     - conversion request (ignored while busy)
//   busy     - conversion in progress
//   done     - one-cycle pulse in the COMMIT cycle
//   anode    - active-low digit enables, anode[0] = ones digit
//   segments - active-low {g,f,e,d,c,b,a} for the enabled digit
module seven_seg_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] num,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [3:0]  anode,
    output logic [6:0]  segments
);
    import seven_seg_pkg::*;

    localparam int unsigned CntW   = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    // Conversion datapath and FSM
    state_e             state_q, state_d;
    logic [NUM_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [BCD_W-1:0]   digits_q, digits_d;

    // Display scan
    logic [CntW-1:0]    refresh_q, refresh_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         anode_q;
    logic [6:0]         seg_q;

    logic [3:0]         cur_digit;
    logic               cur_blank;
    logic [6:0]         dec_seg;
    logic               zero_3, zero_32, zero_321;

    // Add-3 correction on every nibble >= 5, applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bcd_d    = bcd_q;
        bitcnt_d = bitcnt_q;
        digits_d = digits_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shreg_d  = num;
                    bcd_d    = '0;
                    bitcnt_d = BIT_CNT_INIT;
                    state_d  = StConvert;
                end
            end
            StConvert: begin
                // Scratch and shift register move left as one 29-bit word.
                bcd_d   = {bcd_adj[BCD_W-2:0], shreg_q[NUM_W-1]};
                shreg_d = {shreg_q[NUM_W-2:0], 1'b0};
                if (bitcnt_q == 4'd0) begin
                    state_d = StCommit;
                end else begin
                    bitcnt_d = bitcnt_q - 4'd1;
                end
            end
            StCommit: begin
                digits_d = bcd_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StCommit);

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == CntMax) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end
    end

    // A digit is a leading zero when it and every higher digit are zero.
    assign zero_3   = (digits_q[15:12] == 4'd0);
    assign zero_32  = zero_3 && (digits_q[11:8] == 4'd0);
    assign zero_321 = zero_32 && (digits_q[7:4] == 4'd0);

    always_comb begin
        cur_blank = 1'b0;
        unique case (idx_q)
            2'd3:    cur_blank = zero_3;
            2'd2:    cur_blank = zero_32;
            2'd1:    cur_blank = zero_321;
            default: cur_blank = 1'b0;
        endcase
        cur_blank = cur_blank && BLANK_LZ;
    end

    assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .digit_i (cur_digit),
        .blank_i (cur_blank),
        .seg_o   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bcd_q     <= '0;
            bitcnt_q  <= '0;
            digits_q  <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            anode_q   <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bcd_q     <= bcd_d;
            bitcnt_q  <= bitcnt_d;
            digits_q  <= digits_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            anode_q   <= ~(4'b0001 << idx_q);
            seg_q     <= dec_seg;
        end
    end

    assign anode    = anode_q;
    assign segments = seg_q;

endmodule

// File: doc/seven_seg_ctrl.md
SEVEN_SEG_CTRL -- requirements
Module: seven_seg_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clock cycles each digit stays enabled; legal range 2 or more.
REQ-002 Parameter BLANK_LZ, default 1: 1 enables leading-zero blanking.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 num  input  13  unsigned binary value (0..8191); sampled only on an accepted load.
REQ-006 load  input  1  conversion request strobe.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  single-cycle pulse when new digits reach the display.
REQ-009 anode  output  4  active-low digit enables; anode[0] is the ones digit (rightmost).
REQ-010 segments  output  7  active-low {g,f,e,d,c,b,a} for the enabled digit.

Function
REQ-011 FSM states: IDLE, CONVERT, COMMIT; busy SHALL equal (state != IDLE).
REQ-012 load accepted only in IDLE; the accepting cycle captures num into a 13-bit shift register, zeroes the 16-bit BCD scratch, sets bit counter to 12, enters CONVERT.
REQ-013 load while busy SHALL be ignored: no capture, no queueing.
REQ-014 CONVERT: one double-dabble iteration per cycle, MSB first. Each BCD nibble >=5 gets +3 (all nibbles in parallel), then the scratch and the shift register shift left one bit as a single unit. The counter decrements.
REQ-015 After the iteration with counter 0 (13 CONVERT cycles total), go to COMMIT.
REQ-016 COMMIT, one cycle: copy scratch into the four display digit registers (thousands, hundreds, tens, ones), assert done, return to IDLE.
REQ-017 Latency: load accepted in cycle N gives busy high in cycles N+1..N+14. done is high in cycle N+14, the COMMIT cycle. New digits are visible from cycle N+15. A load in cycle N+15 is accepted.
REQ-018 Display digit registers SHALL hold their previous value for the whole conversion; no partial results are shown.
REQ-019 Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, the 2-bit scan index increments modulo 4.
REQ-020 anode SHALL drive exactly one low bit, at the scan index position; pattern sequence 1110, 1101, 1011, 0111, repeat.
REQ-021 Segment encoding (gfedcba, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10..15 give 1111111.
REQ-022 With BLANK_LZ=1, a digit whose value and all higher digits are zero SHALL drive 1111111. The ones digit is never blanked.
REQ-023 anode and segments are registered and change together, one cycle after a scan index change.
REQ-024 Scanning runs continuously and independently of the FSM.

Reset
REQ-025 rst high at any edge: state=IDLE, busy=0, done=0, digit registers=0, scratch=0, refresh counter=0, scan index=0, anode=1111, segments=1111111.
REQ-026 Reset during CONVERT or COMMIT aborts the conversion: no done pulse, and digits read 0 afterwards.
REQ-027 rst takes priority over a load asserted in the same cycle.

Structure
REQ-028 Shared package seven_seg_pkg holds the state enum, NUM_DIGITS=4, and the digit-to-segment constant table.
REQ-029 One combinational sub-module seg7_decode (4-bit digit plus blank flag in, 7-bit segments out). All sequencing stays in seven_seg_ctrl.

Verification (bench uses REFRESH_DIV=4)
REQ-030 Reset with no load -> anode steps 1110/1101/1011/0111 every 4 cycles. Only the ones digit shows 1000000; the other digits show 1111111.
REQ-031 load num=1234 -> busy high 14 cycles, done pulse on the 14th. Digits 1,2,3,4 give segments 1111001, 0100100, 0110000, 0011001 on anodes 0111, 1011, 1101, 1110 respectively.
REQ-032 load num=8191 -> digits 8,1,9,1. Then load num=0 -> ones shows 1000000, the rest are blank.
REQ-033 load num=50, then load num=7 at busy cycle 3 -> the second load is ignored. Display reads blank, blank, 5, 0 (BLANK_LZ=1); a BLANK_LZ=0 build reads 0,0,5,0.
REQ-034 load num=999, rst pulsed at busy cycle 5 -> busy=0 next cycle, no done pulse, display shows 0.
REQ-035 load held high continuously with num=42 -> conversions accepted every 15 cycles, done pulses spaced 15 cycles apart, display steady at 42.
